// File: rtl/ex_ma_latch_if.sv
// ex_ma_latch_if: EX-stage inputs, MA-stage outputs and branch redirect of the EX/MA latch
interface ex_ma_latch_if;
  logic        stall;
  logic        flush;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_instr;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_op2;
  logic [31:0] ex_branch_target;
  logic [31:0] ex_ra;
  logic [21:0] ex_ctrl;
  logic [1:0]  ex_flags;
  logic        ma_valid;
  logic [31:0] ma_pc;
  logic [31:0] ma_instr;
  logic [31:0] ma_alu_result;
  logic [31:0] ma_op2;
  logic [21:0] ma_ctrl;
  logic [1:0]  flags_q;
  logic        branch_taken;
  logic [31:0] branch_pc;
  logic [31:0] retire_cnt;
  modport master (
    output stall, flush, ex_valid, ex_pc, ex_instr, ex_alu_result, ex_op2,
           ex_branch_target, ex_ra, ex_ctrl, ex_flags,
    input  ma_valid, ma_pc, ma_instr, ma_alu_result, ma_op2, ma_ctrl, flags_q,
           branch_taken, branch_pc, retire_cnt
  );
  modport slave (
    input  stall, flush, ex_valid, ex_pc, ex_instr, ex_alu_result, ex_op2,
           ex_branch_target, ex_ra, ex_ctrl, ex_flags,
    output ma_valid, ma_pc, ma_instr, ma_alu_result, ma_op2, ma_ctrl, flags_q,
           branch_taken, branch_pc, retire_cnt
  );
endinterface

// File: rtl/ex_ma_latch.sv
// ex_ma_latch: EX/MA pipeline register with flags register, retire counter and branch resolve
module ex_ma_latch (
  input logic          clk,
  input logic          rst_n,
  ex_ma_latch_if.slave bus
);
  logic        valid_q, valid_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d, alu_q, alu_d, op2_q, op2_d;
  logic [21:0] ctrl_q, ctrl_d;
  logic [1:0]  flg_q, flg_d;
  logic [31:0] cnt_q, cnt_d;
  logic        adv;
  // next state: flush squashes, stall holds, otherwise advance
  always_comb begin
    adv     = !bus.flush && !bus.stall;
    valid_d = bus.flush ? 1'b0 : bus.stall ? valid_q : bus.ex_valid;
    pc_d    = bus.flush ? '0 : bus.stall ? pc_q    : bus.ex_pc;
    instr_d = bus.flush ? '0 : bus.stall ? instr_q : bus.ex_instr;
    alu_d   = bus.flush ? '0 : bus.stall ? alu_q   : bus.ex_alu_result;
    op2_d   = bus.flush ? '0 : bus.stall ? op2_q   : bus.ex_op2;
    ctrl_d  = bus.flush ? '0 : bus.stall ? ctrl_q  : bus.ex_ctrl;
    flg_d   = (adv && bus.ex_valid && bus.ex_ctrl[11]) ? bus.ex_flags : flg_q;
    cnt_d   = (adv && bus.ex_valid) ? cnt_q + 32'd1 : cnt_q;
  end
  // pipeline state with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
      alu_q   <= '0;
      op2_q   <= '0;
      ctrl_q  <= '0;
      flg_q   <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      alu_q   <= alu_d;
      op2_q   <= op2_d;
      ctrl_q  <= ctrl_d;
      flg_q   <= flg_d;
      cnt_q   <= cnt_d;
    end
  end
  // branch resolve from registered flags so a cmp directly before beq/bgt is seen
  always_comb begin
    bus.branch_taken = bus.ex_valid & (bus.ex_ctrl[7] | bus.ex_ctrl[8] | bus.ex_ctrl[4] |
                       (bus.ex_ctrl[2] & flg_q[0]) | (bus.ex_ctrl[3] & flg_q[1]));
    bus.branch_pc    = bus.ex_ctrl[4] ? bus.ex_ra : bus.ex_branch_target;
  end
  assign bus.ma_valid      = valid_q;
  assign bus.ma_pc         = pc_q;
  assign bus.ma_instr      = instr_q;
  assign bus.ma_alu_result = alu_q;
  assign bus.ma_op2        = op2_q;
  assign bus.ma_ctrl       = ctrl_q;
  assign bus.flags_q       = flg_q;
  assign bus.retire_cnt    = cnt_q;
endmodule

// File: tb/tb_ex_ma_latch.sv
// tb_ex_ma_latch: directed self-checking bench for the EX/MA latch
module tb_ex_ma_latch;
  localparam logic [21:0] CMP = 22'h000800;
  localparam logic [21:0] BEQ = 22'h000004;
  localparam logic [21:0] BGT = 22'h000008;
  localparam logic [21:0] RET = 22'h000010;
  localparam logic [21:0] WB  = 22'h000040;
  localparam logic [21:0] UBR = 22'h000080;
  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;
  ex_ma_latch_if bus();
  ex_ma_latch dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic ex(input logic v, input logic [21:0] c, input logic [1:0] f, input logic [31:0] pc);
    bus.ex_valid         = v;
    bus.ex_ctrl          = c;
    bus.ex_flags         = f;
    bus.ex_pc            = pc;
    bus.ex_instr         = pc ^ 32'hA5A5_0000;
    bus.ex_alu_result    = pc + 32'd7;
    bus.ex_op2           = pc + 32'd9;
    bus.ex_branch_target = 32'h40;
    bus.ex_ra            = 32'h80;
  endtask
  initial begin
    rst_n = 1'b0;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    ex(1'b1, CMP, 2'b11, 32'h10);
    #2;
    chk("rst_valid", {31'd0, bus.ma_valid}, 32'd0);
    chk("rst_pc", bus.ma_pc, 32'd0);
    chk("rst_ctrl", {10'd0, bus.ma_ctrl}, 32'd0);
    chk("rst_flags", {30'd0, bus.flags_q}, 32'd0);
    chk("rst_cnt", bus.retire_cnt, 32'd0);
    tick();
    chk("rst_hold_valid", {31'd0, bus.ma_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ex(1'b1, CMP, 2'b01, 32'h100);
    #1;
    chk("cmp_no_branch", {31'd0, bus.branch_taken}, 32'd0);
    tick();
    chk("s1_flags", {30'd0, bus.flags_q}, 32'd1);
    chk("s1_valid", {31'd0, bus.ma_valid}, 32'd1);
    chk("s1_pc", bus.ma_pc, 32'h100);
    chk("s1_instr", bus.ma_instr, 32'hA5A5_0100);
    chk("s1_alu", bus.ma_alu_result, 32'h107);
    chk("s1_op2", bus.ma_op2, 32'h109);
    chk("s1_ctrl", {10'd0, bus.ma_ctrl}, 32'h800);
    chk("s1_cnt", bus.retire_cnt, 32'd1);
    ex(1'b1, BEQ, 2'b00, 32'h104);
    #1;
    chk("s1_beq_taken", {31'd0, bus.branch_taken}, 32'd1);
    chk("s1_beq_pc", bus.branch_pc, 32'h40);
    tick();
    chk("s1_beq_flags_hold", {30'd0, bus.flags_q}, 32'd1);
    chk("s1_beq_cnt", bus.retire_cnt, 32'd2);
    ex(1'b1, WB, 2'b10, 32'h108);
    tick();
    chk("s2_add_flags", {30'd0, bus.flags_q}, 32'd1);
    chk("s2_add_cnt", bus.retire_cnt, 32'd3);
    ex(1'b1, BGT, 2'b10, 32'h10C);
    #1;
    chk("s2_bgt_taken", {31'd0, bus.branch_taken}, 32'd0);
    ex(1'b1, RET, 2'b00, 32'h10C);
    #1;
    chk("ret_taken", {31'd0, bus.branch_taken}, 32'd1);
    chk("ret_pc", bus.branch_pc, 32'h80);
    ex(1'b0, UBR, 2'b00, 32'h10C);
    #1;
    chk("invalid_ubr", {31'd0, bus.branch_taken}, 32'd0);
    ex(1'b1, BGT, 2'b10, 32'h10C);
    tick();
    chk("bgt_cnt", bus.retire_cnt, 32'd4);
    chk("bgt_ctrl", {10'd0, bus.ma_ctrl}, 32'h8);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ex(1'b1, CMP, 2'b10, 32'h200 + 32'(i) * 32'h100);
      tick();
      chk("s3_pc", bus.ma_pc, 32'h10C);
      chk("s3_ctrl", {10'd0, bus.ma_ctrl}, 32'h8);
      chk("s3_flags", {30'd0, bus.flags_q}, 32'd1);
      chk("s3_cnt", bus.retire_cnt, 32'd4);
    end
    bus.stall = 1'b0;
    tick();
    chk("s3_rel_pc", bus.ma_pc, 32'h400);
    chk("s3_rel_flags", {30'd0, bus.flags_q}, 32'd2);
    chk("s3_rel_cnt", bus.retire_cnt, 32'd5);
    bus.stall = 1'b1;
    bus.flush = 1'b1;
    ex(1'b1, CMP | UBR, 2'b11, 32'h500);
    #1;
    chk("s4_branch_indep", {31'd0, bus.branch_taken}, 32'd1);
    tick();
    chk("s4_valid", {31'd0, bus.ma_valid}, 32'd0);
    chk("s4_pc", bus.ma_pc, 32'd0);
    chk("s4_ctrl", {10'd0, bus.ma_ctrl}, 32'd0);
    chk("s4_flags", {30'd0, bus.flags_q}, 32'd2);
    chk("s4_cnt", bus.retire_cnt, 32'd5);
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    ex(1'b0, CMP, 2'b11, 32'h600);
    tick();
    chk("bubble_valid", {31'd0, bus.ma_valid}, 32'd0);
    chk("bubble_pc", bus.ma_pc, 32'h600);
    chk("bubble_flags", {30'd0, bus.flags_q}, 32'd2);
    chk("bubble_cnt", bus.retire_cnt, 32'd5);
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_q;
    chk("s5_preload", bus.retire_cnt, 32'hFFFF_FFFF);
    ex(1'b1, WB, 2'b00, 32'h700);
    tick();
    chk("s5_wrap", bus.retire_cnt, 32'd0);
    ex(1'b1, CMP, 2'b11, 32'h704);
    tick();
    chk("s6_pre_valid", {31'd0, bus.ma_valid}, 32'd1);
    chk("s6_pre_flags", {30'd0, bus.flags_q}, 32'd3);
    chk("s6_pre_cnt", bus.retire_cnt, 32'd1);
    #1;
    bus.stall = 1'b1;
    bus.flush = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("s6_valid", {31'd0, bus.ma_valid}, 32'd0);
    chk("s6_flags", {30'd0, bus.flags_q}, 32'd0);
    chk("s6_cnt", bus.retire_cnt, 32'd0);
    chk("s6_pc", bus.ma_pc, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    ex(1'b1, CMP, 2'b01, 32'h800);
    tick();
    chk("post_rst_valid", {31'd0, bus.ma_valid}, 32'd1);
    chk("post_rst_flags", {30'd0, bus.flags_q}, 32'd1);
    chk("post_rst_cnt", bus.retire_cnt, 32'd1);
    chk("post_rst_pc", bus.ma_pc, 32'h800);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
